// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
//    Decode-side micro-op sequencer for LM/SM (load/store multiple) instructions.
//    It takes the LM/SM word from the IF/ID register and expands its 8-bit register
//    mask into one micro-op per set bit, in ascending register order. Micro-op
//    addresses run base, base+1, ... in issue order. Fetch is held (pc_hold) until
//    the last micro-op issues.
//
// Ports
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    ir_in        instruction word from the IF/ID register
//    ir_valid     ir_in holds a valid instruction this cycle
//    base_addr    RA value read for ir_in, sampled on start
//    id_stall     downstream stall, no micro-op may issue this cycle
//    flush        kill the current or starting sequence
//    busy         sequencer is in the ISSUE state
//    pc_hold      hold PC and IF/ID this cycle
//    uop_valid    a micro-op issues this cycle
//    uop_is_load  1 = LM load micro-op, 0 = SM store micro-op
//    uop_reg      register index of the micro-op
//    uop_addr     memory address of the micro-op (wraps modulo 2^ADDR_W)
//    uop_last     this micro-op is the final one of the sequence
module lm_sm_sequencer #(
   parameter int unsigned ADDR_W = 16,
   parameter logic [3:0]  LM_OP  = 4'b0110,
   parameter logic [3:0]  SM_OP  = 4'b0111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       ir_in,
   input  logic              ir_valid,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              id_stall,
   input  logic              flush,
   output logic              busy,
   output logic              pc_hold,
   output logic              uop_valid,
   output logic              uop_is_load,
   output logic [2:0]        uop_reg,
   output logic [ADDR_W-1:0] uop_addr,
   output logic              uop_last
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t            state, state_nx;
   logic [7:0]        mask, mask_nx;
   logic [ADDR_W-1:0] base, base_nx;
   logic [2:0]        offset, offset_nx;
   logic              is_load, is_load_nx;

   logic [3:0]        op;
   logic              op_ok;
   logic              start;
   logic              issuing;
   logic              one_bit;
   logic [2:0]        low_idx;

   // RA field is consumed upstream (base_addr); it is not needed here.
   logic              ra_unused;
   assign ra_unused = ^ir_in[11:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mask    <= '0;
         base    <= '0;
         offset  <= '0;
         is_load <= 1'b0;
      end else begin
         state   <= state_nx;
         mask    <= mask_nx;
         base    <= base_nx;
         offset  <= offset_nx;
         is_load <= is_load_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      mask_nx    = mask;
      base_nx    = base;
      offset_nx  = offset;
      is_load_nx = is_load;
      low_idx    = '0;

      op      = ir_in[15:12];
      op_ok   = (op == LM_OP) || (op == SM_OP);
      issuing = (state == ISSUE);
      // Gating with rst_n keeps pc_hold at 0 while reset is asserted even if a
      // valid LM/SM word sits on ir_in.
      start   = rst_n && (state == IDLE) && ir_valid && !flush && op_ok
                && (ir_in[7:0] != '0);

      // Priority scan from the top so the lowest set bit wins.
      for (int unsigned i = 8; i > 0; i--) begin
         if (mask[i-1]) low_idx = 3'(i - 1);
      end
      one_bit = (mask != '0) && ((mask & (mask - 8'd1)) == '0);

      uop_valid   = issuing && !id_stall && !flush;
      uop_last    = uop_valid && one_bit;
      uop_reg     = low_idx;
      uop_addr    = base + ADDR_W'(offset);
      uop_is_load = is_load;
      busy        = issuing;
      pc_hold     = !flush && (start || (issuing && !uop_last) || (issuing && id_stall));

      if (flush) begin
         state_nx = IDLE;
         mask_nx  = '0;
      end else if (start) begin
         state_nx   = ISSUE;
         mask_nx    = ir_in[7:0];
         base_nx    = base_addr;
         offset_nx  = '0;
         is_load_nx = (op == LM_OP);
      end else if (uop_valid) begin
         mask_nx   = mask & (mask - 8'd1);
         offset_nx = offset + 3'd1;
         if (uop_last) state_nx = IDLE;
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

   localparam logic [3:0] LM = 4'b0110;
   localparam logic [3:0] SM = 4'b0111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] ir_in;
   logic        ir_valid;
   logic [15:0] base_addr;
   logic        id_stall;
   logic        flush;
   logic        busy;
   logic        pc_hold;
   logic        uop_valid;
   logic        uop_is_load;
   logic [2:0]  uop_reg;
   logic [15:0] uop_addr;
   logic        uop_last;

   lm_sm_sequencer #(
      .ADDR_W(16),
      .LM_OP (4'b0110),
      .SM_OP (4'b0111)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ir_in      (ir_in),
      .ir_valid   (ir_valid),
      .base_addr  (base_addr),
      .id_stall   (id_stall),
      .flush      (flush),
      .busy       (busy),
      .pc_hold    (pc_hold),
      .uop_valid  (uop_valid),
      .uop_is_load(uop_is_load),
      .uop_reg    (uop_reg),
      .uop_addr   (uop_addr),
      .uop_last   (uop_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  r;
      logic [15:0] a;
      logic        ld;
      logic        last;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [7:0] m);
      return {op, 4'h2, m};
   endfunction

   task automatic push(input logic [2:0] r, input logic [15:0] a, input logic ld, input logic last);
      exp_t e;
      e.r = r; e.a = a; e.ld = ld; e.last = last;
      q.push_back(e);
   endtask

   // One cycle: sample at the falling edge, score any issued micro-op against the
   // queue, check the control outputs, then advance past the next rising edge.
   task automatic step(input string tag, input logic e_pc, input logic e_busy, input logic e_valid);
      exp_t e;
      @(negedge clk);
      check({tag, ".valid"}, uop_valid, e_valid);
      check({tag, ".pc_hold"}, pc_hold, e_pc);
      check({tag, ".busy"}, busy, e_busy);
      if (uop_valid) begin
         if (q.size() == 0) begin
            check({tag, ".unexpected_uop"}, 1, 0);
         end else begin
            e = q.pop_front();
            check({tag, ".reg"}, uop_reg, e.r);
            check({tag, ".addr"}, uop_addr, e.a);
            check({tag, ".load"}, uop_is_load, e.ld);
            check({tag, ".last"}, uop_last, e.last);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drained(input string tag);
      check({tag, ".queue_left"}, q.size(), 0);
      q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ir_in = '0; ir_valid = 1'b0; base_addr = '0;
      id_stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.busy", busy, 0);
      check("rst.pc_hold", pc_hold, 0);
      check("rst.valid", uop_valid, 0);
      check("rst.addr", uop_addr, 0);
      rst_n = 1'b1;

      // LM mask 0x05 at 0x0100
      ir_in = mk(LM, 8'h05); ir_valid = 1'b1; base_addr = 16'h0100;
      push(3'd0, 16'h0100, 1'b1, 1'b0);
      push(3'd2, 16'h0101, 1'b1, 1'b1);
      step("lm05.start", 1, 0, 0);
      ir_valid = 1'b0;
      step("lm05.c1", 1, 1, 1);
      step("lm05.c2", 0, 1, 1);
      step("lm05.c3", 0, 0, 0);
      drained("lm05");

      // SM mask 0xFF at 0xFFFE, address wraps
      ir_in = mk(SM, 8'hFF); ir_valid = 1'b1; base_addr = 16'hFFFE;
      for (int i = 0; i < 8; i++) push(3'(i), 16'hFFFE + 16'(i), 1'b0, (i == 7));
      step("smff.start", 1, 0, 0);
      ir_valid = 1'b0;
      for (int i = 0; i < 8; i++) step("smff.issue", (i != 7), 1, 1);
      step("smff.after", 0, 0, 0);
      drained("smff");

      // zero mask LM and a plain ADD pass through
      ir_in = mk(LM, 8'h00); ir_valid = 1'b1; base_addr = 16'h1234;
      step("lm00", 0, 0, 0);
      ir_in = 16'h0000;
      step("add", 0, 0, 0);
      ir_valid = 1'b0;
      step("nop.after", 0, 0, 0);
      drained("nop");

      // LM mask 0x81 with a two-cycle stall between the micro-ops
      ir_in = mk(LM, 8'h81); ir_valid = 1'b1; base_addr = 16'h0020;
      push(3'd0, 16'h0020, 1'b1, 1'b0);
      push(3'd7, 16'h0021, 1'b1, 1'b1);
      step("lm81.start", 1, 0, 0);
      ir_valid = 1'b0;
      step("lm81.r0", 1, 1, 1);
      id_stall = 1'b1;
      step("lm81.stall1", 1, 1, 0);
      step("lm81.stall2", 1, 1, 0);
      id_stall = 1'b0;
      step("lm81.r7", 0, 1, 1);
      step("lm81.after", 0, 0, 0);
      drained("lm81");

      // LM mask 0x0F flushed on the second issue cycle, then a fresh start
      ir_in = mk(LM, 8'h0F); ir_valid = 1'b1; base_addr = 16'h0200;
      push(3'd0, 16'h0200, 1'b1, 1'b0);
      step("lm0f.start", 1, 0, 0);
      ir_valid = 1'b0;
      step("lm0f.r0", 1, 1, 1);
      flush = 1'b1;
      step("lm0f.flush", 0, 1, 0);
      flush = 1'b0;
      step("lm0f.after", 0, 0, 0);
      drained("lm0f");
      ir_in = mk(LM, 8'h02); ir_valid = 1'b1; base_addr = 16'h0300;
      push(3'd1, 16'h0300, 1'b1, 1'b1);
      step("lm02.start", 1, 0, 0);
      ir_valid = 1'b0;
      step("lm02.r1", 0, 1, 1);
      step("lm02.after", 0, 0, 0);
      drained("lm02");

      // async reset in the middle of LM mask 0xF0
      ir_in = mk(LM, 8'hF0); ir_valid = 1'b1; base_addr = 16'h0050;
      push(3'd4, 16'h0050, 1'b1, 1'b0);
      push(3'd5, 16'h0051, 1'b1, 1'b0);
      step("lmf0.start", 1, 0, 0);
      ir_valid = 1'b0;
      step("lmf0.r4", 1, 1, 1);
      step("lmf0.r5", 1, 1, 1);
      drained("lmf0");
      #2;
      rst_n = 1'b0;
      ir_in = mk(LM, 8'h01); ir_valid = 1'b1; base_addr = 16'h0400;
      #1;
      check("arst.busy", busy, 0);
      check("arst.pc_hold", pc_hold, 0);
      check("arst.valid", uop_valid, 0);
      check("arst.reg", uop_reg, 0);
      check("arst.addr", uop_addr, 0);
      check("arst.load", uop_is_load, 0);
      check("arst.last", uop_last, 0);
      @(posedge clk);
      #1;
      check("arst.held_busy", busy, 0);
      rst_n = 1'b1;
      push(3'd0, 16'h0400, 1'b1, 1'b1);
      step("lm01.start", 1, 0, 0);
      ir_valid = 1'b0;
      step("lm01.r0", 0, 1, 1);
      step("lm01.after", 0, 0, 0);
      drained("lm01");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
